// File: rtl/imm_pkg.sv
// Shared types, opcode constants and the immediate extension helper for the
// immediate generator stage.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_J    = 3'd3,
        IMM_U    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_NONE = 3'd7
    } imm_type_e;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Extends to the widest supported XLEN; callers truncate to their own
    // XLEN, which is identical to extending directly to that width.
    function automatic logic [MAX_XLEN-1:0] imm_extend(input logic [31:0] instr,
                                                       input imm_type_e  imm_type);
        logic [MAX_XLEN-1:0] r;
        r = '0;
        case (imm_type)
            IMM_I:   r = {{52{instr[31]}}, instr[31:20]};
            IMM_S:   r = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   r = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   r = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   r = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_Z:   r = {59'b0, instr[19:15]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: picks the format from the opcode and
// produces the extended immediate, format tag and illegal flag.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        // Opcodes not ending in 2'b11 never match and fall to the default.
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: imm_type = IMM_I;
            OP_SYSTEM:                          imm_type = instr[14] ? IMM_Z : IMM_I;
            OP_STORE:                           imm_type = IMM_S;
            OP_BRANCH:                          imm_type = IMM_B;
            OP_JAL:                             imm_type = IMM_J;
            OP_LUI, OP_AUIPC:                   imm_type = IMM_U;
            OP_OP:                              imm_type = IMM_NONE;
            default:                            illegal  = 1'b1;
        endcase
    end

    always_comb begin
        imm = XLEN'(imm_extend(instr, imm_type));
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage with PC-relative target, sitting behind
// a valid/ready handshake with an optional two-entry skid buffer.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_type_e       out_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    // Handshake: a word moves on any rising edge where valid && ready; the
    // producer keeps valid and its payload stable until that edge, and
    // out_* never change while out_valid is high and out_ready is low.

    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    imm_type_e       dec_type;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr    (in_instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign dec_target = in_pc + dec_imm;

    logic            m_valid;
    logic [XLEN-1:0] m_imm;
    logic [XLEN-1:0] m_target;
    imm_type_e       m_type;
    logic            m_illegal;

    logic accept;
    logic drain;

    assign accept      = in_valid && in_ready;
    assign drain       = m_valid && out_ready;
    assign out_valid   = m_valid;
    assign out_imm     = m_imm;
    assign out_type    = m_type;
    assign out_target  = m_target;
    assign out_illegal = m_illegal;

    generate
        if (SKID != 0) begin : g_skid
            logic            k_valid;
            logic [XLEN-1:0] k_imm;
            logic [XLEN-1:0] k_target;
            imm_type_e       k_type;
            logic            k_illegal;

            // Ready comes straight off a flop, so no combinational path from out_ready.
            assign in_ready = !k_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid   <= 1'b0;
                    m_imm     <= '0;
                    m_target  <= '0;
                    m_type    <= IMM_I;
                    m_illegal <= 1'b0;
                    k_valid   <= 1'b0;
                    k_imm     <= '0;
                    k_target  <= '0;
                    k_type    <= IMM_I;
                    k_illegal <= 1'b0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                    k_valid <= 1'b0;
                end else if (!m_valid || drain) begin
                    if (k_valid) begin
                        m_valid   <= 1'b1;
                        m_imm     <= k_imm;
                        m_target  <= k_target;
                        m_type    <= k_type;
                        m_illegal <= k_illegal;
                        k_valid   <= 1'b0;
                    end else begin
                        m_valid <= accept;
                        if (accept) begin
                            m_imm     <= dec_imm;
                            m_target  <= dec_target;
                            m_type    <= dec_type;
                            m_illegal <= dec_illegal;
                        end
                    end
                end else if (accept) begin
                    // M is stalled, so the new word parks in K.
                    k_valid   <= 1'b1;
                    k_imm     <= dec_imm;
                    k_target  <= dec_target;
                    k_type    <= dec_type;
                    k_illegal <= dec_illegal;
                end
            end
        end else begin : g_single
            assign in_ready = !m_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_valid   <= 1'b0;
                    m_imm     <= '0;
                    m_target  <= '0;
                    m_type    <= IMM_I;
                    m_illegal <= 1'b0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                end else if (accept) begin
                    m_valid   <= 1'b1;
                    m_imm     <= dec_imm;
                    m_target  <= dec_target;
                    m_type    <= dec_type;
                    m_illegal <= dec_illegal;
                end else if (drain) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32/64 skid instances share one stream, a
// SKID=0 instance runs its own; all outputs are scored against a reference model.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;

    logic        a_valid = 1'b0;
    logic [31:0] a_instr = '0;
    logic [63:0] a_pc = '0;
    logic        a_ordy = 1'b1;

    logic        b_valid = 1'b0;
    logic [31:0] b_instr = '0;
    logic [31:0] b_pc = '0;
    logic        b_ordy = 1'b1;

    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [2:0]  r32_out_type;
    logic [31:0] r32_out_imm, r32_out_target;
    logic        r64_in_ready, r64_out_valid, r64_out_illegal;
    logic [2:0]  r64_out_type;
    logic [63:0] r64_out_imm, r64_out_target;
    logic        r0_in_ready, r0_out_valid, r0_out_illegal;
    logic [2:0]  r0_out_type;
    logic [31:0] r0_out_imm, r0_out_target;

    int tests = 0;
    int fails = 0;

    logic [131:0] q32[$];
    logic [131:0] q64[$];
    logic [131:0] q0[$];

    logic         hold32 = 1'b0, hold64 = 1'b0, hold0 = 1'b0;
    logic [131:0] sv32, sv64, sv0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .SKID(1)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_valid), .in_ready(r32_in_ready), .in_instr(a_instr), .in_pc(a_pc[31:0]),
        .out_valid(r32_out_valid), .out_ready(a_ordy), .out_imm(r32_out_imm),
        .out_type(r32_out_type), .out_target(r32_out_target), .out_illegal(r32_out_illegal)
    );

    imm_gen_stage #(.XLEN(64), .SKID(1)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_valid), .in_ready(r64_in_ready), .in_instr(a_instr), .in_pc(a_pc),
        .out_valid(r64_out_valid), .out_ready(a_ordy), .out_imm(r64_out_imm),
        .out_type(r64_out_type), .out_target(r64_out_target), .out_illegal(r64_out_illegal)
    );

    imm_gen_stage #(.XLEN(32), .SKID(0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_valid), .in_ready(r0_in_ready), .in_instr(b_instr), .in_pc(b_pc),
        .out_valid(r0_out_valid), .out_ready(b_ordy), .out_imm(r0_out_imm),
        .out_type(r0_out_type), .out_target(r0_out_target), .out_illegal(r0_out_illegal)
    );

    // Reference: immediate value computed arithmetically from the field weights.
    function automatic logic [131:0] model(input logic [31:0] instr, input logic [63:0] pc,
                                           input int xlen);
        longint     v;
        logic [2:0] t;
        logic       ill;
        logic [63:0] mask, imm, tgt;
        v = 0; t = 3'd7; ill = 1'b0;
        case (instr[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: t = 3'd0;
            7'h73:        t = instr[14] ? 3'd5 : 3'd0;
            7'h23:        t = 3'd1;
            7'h63:        t = 3'd2;
            7'h6F:        t = 3'd3;
            7'h37, 7'h17: t = 3'd4;
            7'h33:        t = 3'd7;
            default:      ill = 1'b1;
        endcase
        case (t)
            3'd0: begin
                v = longint'(instr[31:20]);
                if (v >= 2048) v -= 4096;
            end
            3'd1: begin
                v = longint'(instr[31:25]) * 32 + longint'(instr[11:7]);
                if (v >= 2048) v -= 4096;
            end
            3'd2: begin
                v = longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048
                  + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = longint'(instr[31]) * 1048576 + longint'(instr[19:12]) * 4096
                  + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            3'd4: begin
                v = longint'(instr[31:12]) * 4096;
                if (v >= 64'sd2147483648) v -= 64'sd4294967296;
            end
            3'd5:    v = longint'(instr[19:15]);
            default: v = 0;
        endcase
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        imm  = 64'(v) & mask;
        tgt  = (pc + imm) & mask;
        return {ill, t, tgt, imm};
    endfunction

    function automatic logic [131:0] obs32();
        return {r32_out_illegal, r32_out_type, 32'b0, r32_out_target, 32'b0, r32_out_imm};
    endfunction
    function automatic logic [131:0] obs64();
        return {r64_out_illegal, r64_out_type, r64_out_target, r64_out_imm};
    endfunction
    function automatic logic [131:0] obs0();
        return {r0_out_illegal, r0_out_type, 32'b0, r0_out_target, 32'b0, r0_out_imm};
    endfunction

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[12];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};
        r = $urandom();
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    task automatic clear_sb();
        q32.delete(); q64.delete(); q0.delete();
        hold32 = 1'b0; hold64 = 1'b0; hold0 = 1'b0;
    endtask

    // Called after inputs are driven in the low phase; scores the coming edge.
    task automatic tick();
        #1;
        if (hold32) chk("hold32", obs32(), sv32);
        if (hold64) chk("hold64", obs64(), sv64);
        if (hold0)  chk("hold0", obs0(), sv0);
        chk("rdy_match", 132'(r64_in_ready), 132'(r32_in_ready));
        if (flush) begin
            clear_sb();
        end else begin
            if (r32_out_valid && a_ordy) begin
                if (q32.size() == 0) chk("unexp32", 132'(r32_out_valid), 132'(0));
                else chk("out32", obs32(), q32.pop_front());
            end
            if (r64_out_valid && a_ordy) begin
                if (q64.size() == 0) chk("unexp64", 132'(r64_out_valid), 132'(0));
                else chk("out64", obs64(), q64.pop_front());
            end
            if (r0_out_valid && b_ordy) begin
                if (q0.size() == 0) chk("unexp0", 132'(r0_out_valid), 132'(0));
                else chk("out0", obs0(), q0.pop_front());
            end
            if (a_valid && r32_in_ready) begin
                q32.push_back(model(a_instr, {32'b0, a_pc[31:0]}, 32));
                q64.push_back(model(a_instr, a_pc, 64));
            end
            if (b_valid && r0_in_ready) q0.push_back(model(b_instr, {32'b0, b_pc}, 32));
            hold32 = r32_out_valid && !a_ordy; sv32 = obs32();
            hold64 = r64_out_valid && !a_ordy; sv64 = obs64();
            hold0  = r0_out_valid && !b_ordy;  sv0  = obs0();
        end
        @(posedge clk);
    endtask

    task automatic send_check(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                              input logic [131:0] exp64, input logic [131:0] exp32);
        @(negedge clk);
        a_valid = 1'b1; a_instr = instr; a_pc = pc; a_ordy = 1'b1;
        tick();
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk({tag, "_valid"}, 132'({r32_out_valid, r64_out_valid}), 132'(2'b11));
        chk({tag, "_64"}, obs64(), exp64);
        chk({tag, "_32"}, obs32(), exp32);
        tick();
    endtask

    task automatic step_a(input string tag, input logic v, input logic [31:0] instr,
                          input logic o, input logic f, input logic exp_rdy);
        @(negedge clk);
        a_valid = v; a_instr = instr; a_pc = {$urandom(), $urandom()}; a_ordy = o; flush = f;
        #1;
        chk(tag, 132'(r32_in_ready), 132'(exp_rdy));
        tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl32"}, 132'({r32_out_valid, r32_in_ready}), 132'(2'b01));
        chk({tag, "_ctl64"}, 132'({r64_out_valid, r64_in_ready}), 132'(2'b01));
        chk({tag, "_ctl0"},  132'({r0_out_valid, r0_in_ready}),   132'(2'b01));
        chk({tag, "_dat32"}, obs32(), 132'(0));
        chk({tag, "_dat64"}, obs64(), 132'(0));
        chk({tag, "_dat0"},  obs0(),  132'(0));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset("rst_init");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        send_check("addi", 32'hFFF00093, 64'h100,
                   {1'b0, 3'd0, 64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FFFF},
                   {1'b0, 3'd0, 64'h0000_0000_0000_00FF, 64'h0000_0000_FFFF_FFFF});
        send_check("lui", 32'h800000B7, 64'h0,
                   {1'b0, 3'd4, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000},
                   {1'b0, 3'd4, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000});
        send_check("beq_wrap", 32'hFE000EE3, 64'h0,
                   {1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC},
                   {1'b0, 3'd2, 64'h0000_0000_FFFF_FFFC, 64'h0000_0000_FFFF_FFFC});
        send_check("csrrwi", 32'h3402D073, 64'h1000,
                   {1'b0, 3'd5, 64'h1005, 64'h5}, {1'b0, 3'd5, 64'h1005, 64'h5});
        send_check("bad_op", 32'h0000007F, 64'h40,
                   {1'b1, 3'd7, 64'h40, 64'h0}, {1'b1, 3'd7, 64'h40, 64'h0});
        send_check("bad_low", 32'h00000010, 64'h8,
                   {1'b1, 3'd7, 64'h8, 64'h0}, {1'b1, 3'd7, 64'h8, 64'h0});

        // Four-word stream with the consumer stalled for two cycles.
        step_a("skid_rdy1", 1'b1, 32'h00100093, 1'b0, 1'b0, 1'b1);
        step_a("skid_rdy2", 1'b1, 32'h00200113, 1'b0, 1'b0, 1'b1);
        step_a("skid_rdy3", 1'b1, 32'h00300193, 1'b1, 1'b0, 1'b0);
        step_a("skid_rdy4", 1'b1, 32'h00300193, 1'b1, 1'b0, 1'b1);
        step_a("skid_rdy5", 1'b1, 32'h00400213, 1'b1, 1'b0, 1'b1);
        step_a("skid_rdy6", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        step_a("skid_rdy7", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("skid_drained", 132'(q32.size() + q64.size()), 132'(0));

        // Flush with M and K full and a word offered on every instance.
        @(negedge clk);
        b_valid = 1'b1; b_instr = 32'h00500293; b_pc = 32'h20; b_ordy = 1'b0;
        a_valid = 1'b1; a_instr = 32'h00600313; a_pc = 64'h30; a_ordy = 1'b0;
        tick();
        @(negedge clk);
        b_valid = 1'b0;
        a_instr = 32'h00700393;
        tick();
        step_a("flush_rdy_full", 1'b1, 32'h00800413, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        flush = 1'b1; a_valid = 1'b1; a_ordy = 1'b1; b_valid = 1'b1; b_ordy = 1'b1;
        tick();
        @(negedge clk);
        flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("flush_ov", 132'({r32_out_valid, r64_out_valid, r0_out_valid}), 132'(0));
        chk("flush_rdy", 132'({r32_in_ready, r64_in_ready, r0_in_ready}), 132'(3'b111));
        tick();
        repeat (3) begin @(negedge clk); tick(); end

        // Asynchronous reset between edges with entries in flight.
        @(negedge clk);
        a_valid = 1'b1; a_instr = rand_instr(); a_ordy = 1'b0;
        b_valid = 1'b1; b_instr = rand_instr(); b_ordy = 1'b0;
        tick();
        @(negedge clk);
        a_instr = rand_instr(); b_valid = 1'b0;
        tick();
        @(negedge clk);
        a_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        clear_sb();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; a_ordy = 1'b1; b_ordy = 1'b1;
        #1 check_reset("rst_rel");
        repeat (3) begin @(negedge clk); tick(); end

        // Random traffic with back-pressure and occasional flush on all instances.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            flush   = ($urandom_range(0, 255) == 0);
            a_valid = ($urandom_range(0, 9) < 7);
            a_instr = rand_instr();
            a_pc    = {$urandom(), $urandom()};
            a_ordy  = ($urandom_range(0, 9) < 6);
            b_valid = ($urandom_range(0, 9) < 7);
            b_instr = rand_instr();
            b_pc    = $urandom();
            b_ordy  = ($urandom_range(0, 9) < 6);
            tick();
        end
        @(negedge clk);
        flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_ordy = 1'b1; b_ordy = 1'b1;
        tick();
        repeat (4) begin @(negedge clk); tick(); end
        chk("final_drained", 132'(q32.size() + q64.size() + q0.size()), 132'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, flow-controlled immediate generator. It is the parametrised successor to the combinational extend unit. It decodes the immediate format directly from the opcode instead of taking an external control code, and it supports XLEN of 32 or 64 and CSR zimm. It also produces a PC-relative target and sits between fetch and the register-read stage behind a valid/ready handshake with a skid buffer.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- SKID, 1: 1 gives a 2-entry skid buffer with full throughput; 0 gives a single register with in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock. One clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  imm_type_e format tag.
- out_target  out  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_illegal  out  1  opcode not recognised.

## Operation
Format selection uses opcode in_instr[6:0]:
- I: load 0000011, OP-IMM 0010011, JALR 1100111, FENCE 0001111, and SYSTEM 1110011 when funct3[2]=0.
- Z: SYSTEM when funct3[2]=1; the immediate is zero-extended instr[19:15].
- S: 0100011. B: 1100011. J: 1101111. U: LUI 0110111 and AUIPC 0010111.
- R: OP 0110011 gives type NONE and imm 0.
- Any other opcode gives type NONE, imm 0, out_illegal=1.
- The instruction word must have in_instr[1:0]=2'b11; otherwise out_illegal=1.

Bit layouts are the standard RV32I ones:
- I takes instr[31:20], sign-extended.
- S takes {instr[31:25], instr[11:7]}, sign-extended.
- B takes {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
- J takes {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
- U takes {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.

Type encoding: I=0, S=1, B=2, J=3, U=4, Z=5, NONE=7.

out_target is computed for every entry and wraps modulo 2^XLEN. Consumers use it only for B, J and AUIPC.

Handshake:
- A transfer happens when valid && ready is high at the clock edge.
- Once out_valid is high, out_* must not change until the transfer completes.

Skid buffer (SKID=1):
- Main register M and skid register K.
- in_ready = !K.valid, driven from a register.
- When M holds an entry, out_ready=0, and an input is accepted, the input goes into K.
- When M drains, K moves into M.

## Timing
- Latency: 1 cycle from input accept to out_valid.
- Throughput: one instruction per cycle while out_ready=1, for both SKID values.
- Reset values: out_valid=0, in_ready=1, and out_imm, out_type, out_target, out_illegal all 0. These values hold from rst_n assertion, with no clock needed.
- Reset asserted mid-transfer: the entry is lost, and no output is produced after release.
- flush: M.valid and K.valid clear at the next edge, and in_ready=1 the cycle after. An input accepted in the flush cycle is discarded. flush has priority over simultaneous input and output transfers.
- Simultaneous accept and drain with K empty: M reloads with the new entry and out_valid stays 1.
- K full: in_ready=0. It returns to 1 the cycle after the first out_ready.

## Structure
- Package imm_pkg holds:
  - imm_type_e enum (3 bits),
  - opcode localparams,
  - a function imm_extend(instr, type) parameterised via XLEN.
- Sub-module imm_decode is purely combinational: instr in; imm, type and illegal out.
- imm_gen_stage instantiates imm_decode, the target adder, and the M/K registers.

## Test plan
- XLEN=32, ADDI instr 0xFFF00093 (imm -1), pc 0x100 → next cycle out_imm=0xFFFFFFFF, type I, target 0x000000FF.
- XLEN=64, LUI 0x800000B7 → out_imm=0xFFFFFFFF80000000, type U. BEQ with imm -4 at pc 0x0 → target 0xFFFFFFFFFFFFFFFC, testing wrap-around.
- CSRRWI 0x3402D073 → type Z, out_imm=5. Opcode 0x7F → illegal=1, imm 0.
- SKID=1, stream 4 instructions while out_ready is low for 2 cycles → in_ready drops exactly when K fills, output order is preserved, with no loss or duplication. Random back-pressure over 10k cycles is checked against a scoreboard.
- flush with M and K full plus an input offered → out_valid=0 next cycle, in_ready=1 the cycle after, nothing emitted.
- rst_n asserted asynchronously mid-stream between clock edges → outputs zero immediately. After release, in_ready=1 and out_valid=0.
